// File: rtl/id_hazard_stage_pkg.sv
// Shared encodings for the ID hazard/branch stage: branch modes, ctrl bundle
// bit positions, bubble mask and stall FSM states.
package id_hazard_stage_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int REG_WIDTH   = 4;
  localparam int ALUOP_WIDTH = 4;
  localparam int BR_MODE_W   = 2;

  typedef enum logic [1:0] {
    BR_B   = 2'b00,
    BR_EQZ = 2'b01,
    BR_NEZ = 2'b10,
    BR_LTZ = 2'b11
  } br_mode_e;

  // ctrl bundle is {aluop, regwrite, memtoreg, memread, memwrite}
  localparam int CTRL_MEMWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_REGWRITE = 3;

  // Flags cleared when a bubble is loaded; a bubble must never write state.
  localparam logic [3:0] CTRL_BUBBLE_KILL = (4'b1 << CTRL_REGWRITE) |
                                            (4'b1 << CTRL_MEMREAD)  |
                                            (4'b1 << CTRL_MEMWRITE);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } stall_st_e;

  typedef logic [1:0] need_t;

  function automatic need_t max_need(input need_t a, input need_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/id_hazard_stage_if.sv
// ID-stage bundle, EX feedback and IF control signals of id_hazard_stage.
// slave = the stage itself, master = whoever drives ID/EX inputs.
interface id_hazard_stage_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int REG_WIDTH   = 4,
  parameter int ALUOP_WIDTH = 4,
  parameter int BR_MODE_W   = 2
);
  logic                   id_valid_i;
  logic [ALUOP_WIDTH+3:0] ctrl_i;
  logic [DATA_WIDTH-1:0]  src1_i;
  logic [DATA_WIDTH-1:0]  src2_i;
  logic [DATA_WIDTH-1:0]  memdata_i;
  logic [REG_WIDTH-1:0]   rs1_i;
  logic [REG_WIDTH-1:0]   rs2_i;
  logic                   rs2_used_i;
  logic [REG_WIDTH-1:0]   rd_i;
  logic                   isbranch_i;
  logic                   isjr_i;
  logic [BR_MODE_W-1:0]   br_mode_i;
  logic [DATA_WIDTH-1:0]  rdata1_i;
  logic [DATA_WIDTH-1:0]  br_target_i;
  logic                   ex_memread_i;
  logic                   ex_regwrite_i;
  logic [REG_WIDTH-1:0]   ex_rd_i;
  logic                   ex_ready_i;

  logic                   idex_valid_o;
  logic [ALUOP_WIDTH+3:0] idex_ctrl_o;
  logic [DATA_WIDTH-1:0]  idex_src1_o;
  logic [DATA_WIDTH-1:0]  idex_src2_o;
  logic [DATA_WIDTH-1:0]  idex_memdata_o;
  logic [REG_WIDTH-1:0]   idex_rd_o;
  logic                   stall_o;
  logic                   redirect_o;
  logic [DATA_WIDTH-1:0]  target_o;
  logic                   flush_o;

  modport slave (
    input  id_valid_i, ctrl_i, src1_i, src2_i, memdata_i, rs1_i, rs2_i, rs2_used_i,
           rd_i, isbranch_i, isjr_i, br_mode_i, rdata1_i, br_target_i,
           ex_memread_i, ex_regwrite_i, ex_rd_i, ex_ready_i,
    output idex_valid_o, idex_ctrl_o, idex_src1_o, idex_src2_o, idex_memdata_o,
           idex_rd_o, stall_o, redirect_o, target_o, flush_o
  );

  modport master (
    output id_valid_i, ctrl_i, src1_i, src2_i, memdata_i, rs1_i, rs2_i, rs2_used_i,
           rd_i, isbranch_i, isjr_i, br_mode_i, rdata1_i, br_target_i,
           ex_memread_i, ex_regwrite_i, ex_rd_i, ex_ready_i,
    input  idex_valid_o, idex_ctrl_o, idex_src1_o, idex_src2_o, idex_memdata_o,
           idex_rd_o, stall_o, redirect_o, target_o, flush_o
  );
endinterface

// File: rtl/id_hazard_stage_branch_cond.sv
// Combinational branch/jump resolution: taken decision and redirect target.
// JR always wins the target select (rs1 value is the jump address).
module id_hazard_stage_branch_cond
  import id_hazard_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BR_MODE_W  = 2
) (
  input  logic                  isbranch,
  input  logic                  isjr,
  input  logic [BR_MODE_W-1:0]  br_mode,
  input  logic [DATA_WIDTH-1:0] rdata1,
  input  logic [DATA_WIDTH-1:0] br_target,
  output logic                  taken,
  output logic [DATA_WIDTH-1:0] target
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (br_mode)
      BR_B:    cond = 1'b1;
      BR_EQZ:  cond = (rdata1 == '0);
      BR_NEZ:  cond = (rdata1 != '0);
      BR_LTZ:  cond = rdata1[DATA_WIDTH-1];
      default: cond = 1'b0;
    endcase
  end

  assign taken  = isjr | (isbranch & cond);
  assign target = isjr ? rdata1 : br_target;

endmodule

// File: rtl/id_hazard_stage.sv
// Decode-stage hazard unit: load-use / branch-operand stall counter, branch
// resolution in ID, and the ID/EX pipeline register with EX backpressure.
module id_hazard_stage
  import id_hazard_stage_pkg::*;
#(
  parameter int DATA_WIDTH  = id_hazard_stage_pkg::DATA_WIDTH,
  parameter int REG_WIDTH   = id_hazard_stage_pkg::REG_WIDTH,
  parameter int ALUOP_WIDTH = id_hazard_stage_pkg::ALUOP_WIDTH,
  parameter int BR_MODE_W   = id_hazard_stage_pkg::BR_MODE_W
) (
  input  logic             clk,
  input  logic             rst,
  id_hazard_stage_if.slave bus
);

  typedef struct packed {
    logic [ALUOP_WIDTH+3:0] ctrl;
    logic [DATA_WIDTH-1:0]  src1;
    logic [DATA_WIDTH-1:0]  src2;
    logic [DATA_WIDTH-1:0]  memdata;
    logic [REG_WIDTH-1:0]   rd;
  } idex_t;

  stall_st_e             state, state_nxt;
  need_t                 cnt, cnt_nxt;
  need_t                 need_lu, need_bd, need;
  logic                  bp, hz_stall, stall;
  logic                  taken;
  logic [DATA_WIDTH-1:0] target;
  logic                  idex_valid;
  idex_t                 idex, id_bundle, idex_bubble;

  // Hazard demand in cycles; a load feeding a branch operand needs two.
  always_comb begin
    need_lu = '0;
    need_bd = '0;
    if (bus.id_valid_i) begin
      if (bus.ex_memread_i & bus.ex_regwrite_i &
          ((bus.ex_rd_i == bus.rs1_i) | (bus.rs2_used_i & (bus.ex_rd_i == bus.rs2_i))))
        need_lu = 2'd1;
      if (((bus.isbranch_i & (bus.br_mode_i != BR_B)) | bus.isjr_i) &
          bus.ex_regwrite_i & (bus.ex_rd_i == bus.rs1_i))
        need_bd = bus.ex_memread_i ? 2'd2 : 2'd1;
    end
    need = max_need(need_lu, need_bd);
  end

  assign bp = idex_valid & ~bus.ex_ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Backpressure freezes the counter; the hazard still holds stall high.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hz_stall  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (need != '0) begin
          hz_stall = 1'b1;
          if (!bp) begin
            cnt_nxt   = need - 2'd1;
            state_nxt = (need > 2'd1) ? ST_HOLD : ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        hz_stall = 1'b1;
        if (!bp) begin
          cnt_nxt = cnt - 2'd1;
          if (cnt == 2'd1) state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign stall = hz_stall | bp;

  id_hazard_stage_branch_cond #(
    .DATA_WIDTH (DATA_WIDTH),
    .BR_MODE_W  (BR_MODE_W)
  ) u_branch_cond (
    .isbranch  (bus.isbranch_i),
    .isjr      (bus.isjr_i),
    .br_mode   (bus.br_mode_i),
    .rdata1    (bus.rdata1_i),
    .br_target (bus.br_target_i),
    .taken     (taken),
    .target    (target)
  );

  always_comb begin
    id_bundle.ctrl    = bus.ctrl_i;
    id_bundle.src1    = bus.src1_i;
    id_bundle.src2    = bus.src2_i;
    id_bundle.memdata = bus.memdata_i;
    id_bundle.rd      = bus.rd_i;
    idex_bubble           = id_bundle;
    idex_bubble.ctrl[3:0] = bus.ctrl_i[3:0] & ~CTRL_BUBBLE_KILL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_valid <= 1'b0;
      idex       <= '0;
    end else if (!bp) begin
      if (hz_stall) begin
        idex_valid <= 1'b0;
        idex       <= idex_bubble;
      end else begin
        idex_valid <= bus.id_valid_i;
        idex       <= id_bundle;
      end
    end
  end

  assign bus.idex_valid_o   = idex_valid;
  assign bus.idex_ctrl_o    = idex.ctrl;
  assign bus.idex_src1_o    = idex.src1;
  assign bus.idex_src2_o    = idex.src2;
  assign bus.idex_memdata_o = idex.memdata;
  assign bus.idex_rd_o      = idex.rd;
  assign bus.stall_o        = stall;
  assign bus.redirect_o     = bus.id_valid_i & ~stall & taken;
  assign bus.flush_o        = bus.id_valid_i & ~stall & taken;
  assign bus.target_o       = target;

endmodule

// File: tb/tb_id_hazard_stage.sv
// Bench for id_hazard_stage: directed hazard/branch scenarios followed by
// random traffic, all compared against a cycle-level reference model.
module tb_id_hazard_stage;
  import id_hazard_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_hazard_stage_if bus();

  id_hazard_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // reference model state: ID/EX contents and remaining extra stall cycles
  bit          m_valid, m_bubble;
  logic [7:0]  m_ctrl;
  logic [15:0] m_src1, m_src2, m_mem;
  logic [3:0]  m_rd;
  int          m_left;

  bit          obs_stall, obs_redir, obs_ivalid;
  logic [15:0] obs_tgt, obs_src1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_bubble = 0; m_ctrl = '0; m_src1 = '0; m_src2 = '0;
    m_mem = '0; m_rd = '0; m_left = 0;
  endtask

  task automatic idle_in();
    bus.id_valid_i = 0; bus.ctrl_i = '0; bus.src1_i = '0; bus.src2_i = '0;
    bus.memdata_i = '0; bus.rs1_i = '0; bus.rs2_i = '0; bus.rs2_used_i = 0;
    bus.rd_i = '0; bus.isbranch_i = 0; bus.isjr_i = 0; bus.br_mode_i = '0;
    bus.rdata1_i = '0; bus.br_target_i = '0; bus.ex_memread_i = 0;
    bus.ex_regwrite_i = 0; bus.ex_rd_i = '0; bus.ex_ready_i = 1;
  endtask

  task automatic set_ex(input bit mr, input bit rw, input logic [3:0] rd);
    bus.ex_memread_i = mr; bus.ex_regwrite_i = rw; bus.ex_rd_i = rd;
  endtask

  task automatic set_id(input bit v, input logic [3:0] rs1, input logic [3:0] rs2, input bit used);
    bus.id_valid_i = v; bus.rs1_i = rs1; bus.rs2_i = rs2; bus.rs2_used_i = used;
  endtask

  task automatic set_br(input bit br, input bit jr, input logic [1:0] mode,
                        input logic [15:0] r1, input logic [15:0] tgt);
    bus.isbranch_i = br; bus.isjr_i = jr; bus.br_mode_i = mode;
    bus.rdata1_i = r1; bus.br_target_i = tgt;
  endtask

  task automatic rand_in();
    bus.id_valid_i    = ($urandom_range(0, 9) < 8);
    bus.ctrl_i        = 8'($urandom);
    bus.src1_i        = 16'($urandom);
    bus.src2_i        = 16'($urandom);
    bus.memdata_i     = 16'($urandom);
    bus.rs1_i         = 4'($urandom_range(0, 3));
    bus.rs2_i         = 4'($urandom_range(0, 3));
    bus.rs2_used_i    = 1'($urandom);
    bus.rd_i          = 4'($urandom);
    bus.isbranch_i    = ($urandom_range(0, 2) == 0);
    bus.isjr_i        = ($urandom_range(0, 7) == 0);
    bus.br_mode_i     = 2'($urandom);
    bus.rdata1_i      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
    bus.br_target_i   = 16'($urandom);
    bus.ex_memread_i  = 1'($urandom);
    bus.ex_regwrite_i = ($urandom_range(0, 3) != 0);
    bus.ex_rd_i       = 4'($urandom_range(0, 3));
    bus.ex_ready_i    = ($urandom_range(0, 3) != 0);
  endtask

  // One cycle: predict and compare at negedge, advance the model at posedge.
  task automatic step(input string tag);
    int          need;
    bit          bp, hz, cond, taken, stall, redir;
    logic [15:0] tgt;
    @(negedge clk);
    need = 0;
    if (bus.id_valid_i) begin
      if (bus.ex_memread_i && bus.ex_regwrite_i &&
          (bus.ex_rd_i == bus.rs1_i || (bus.rs2_used_i && bus.ex_rd_i == bus.rs2_i)))
        need = 1;
      if (((bus.isbranch_i && bus.br_mode_i != 2'b00) || bus.isjr_i) &&
          bus.ex_regwrite_i && bus.ex_rd_i == bus.rs1_i)
        need = bus.ex_memread_i ? 2 : 1;
    end
    bp    = m_valid && !bus.ex_ready_i;
    hz    = (m_left > 0) || (need > 0);
    stall = bp || hz;
    case (bus.br_mode_i)
      2'b00:   cond = 1;
      2'b01:   cond = (bus.rdata1_i == 16'h0);
      2'b10:   cond = (bus.rdata1_i != 16'h0);
      default: cond = ($signed(bus.rdata1_i) < 0);
    endcase
    taken = bus.isjr_i || (bus.isbranch_i && cond);
    redir = bus.id_valid_i && !stall && taken;
    tgt   = bus.isjr_i ? bus.rdata1_i : bus.br_target_i;

    obs_stall = bus.stall_o; obs_redir = bus.redirect_o; obs_tgt = bus.target_o;
    obs_ivalid = bus.idex_valid_o; obs_src1 = bus.idex_src1_o;

    chk({tag, ".stall"}, 32'(bus.stall_o), 32'(stall));
    chk({tag, ".redir"}, 32'(bus.redirect_o), 32'(redir));
    chk({tag, ".flush"}, 32'(bus.flush_o), 32'(redir));
    if (redir) chk({tag, ".tgt"}, 32'(bus.target_o), 32'(tgt));
    chk({tag, ".ivalid"}, 32'(bus.idex_valid_o), 32'(m_valid));
    if (m_bubble) begin
      chk({tag, ".bubble"}, 32'(bus.idex_ctrl_o & 8'h0B), 32'(0));
    end else begin
      chk({tag, ".ctrl"}, 32'(bus.idex_ctrl_o), 32'(m_ctrl));
      chk({tag, ".src1"}, 32'(bus.idex_src1_o), 32'(m_src1));
      chk({tag, ".src2"}, 32'(bus.idex_src2_o), 32'(m_src2));
      chk({tag, ".mem"}, 32'(bus.idex_memdata_o), 32'(m_mem));
      chk({tag, ".rd"}, 32'(bus.idex_rd_o), 32'(m_rd));
    end

    @(posedge clk);
    if (!bp) begin
      if (hz) begin
        m_valid = 0; m_bubble = 1;
      end else begin
        m_valid = bus.id_valid_i; m_bubble = 0; m_ctrl = bus.ctrl_i;
        m_src1 = bus.src1_i; m_src2 = bus.src2_i; m_mem = bus.memdata_i; m_rd = bus.rd_i;
      end
      if (m_left > 0) m_left--;
      else if (need > 0) m_left = need - 1;
    end
    #1;
  endtask

  initial begin
    idle_in();
    model_reset();
    #12;
    chk("rst.ivalid", 32'(bus.idex_valid_o), 32'(0));
    chk("rst.ctrl", 32'(bus.idex_ctrl_o), 32'(0));
    chk("rst.src1", 32'(bus.idex_src1_o), 32'(0));
    chk("rst.stall", 32'(bus.stall_o), 32'(0));
    chk("rst.redir", 32'(bus.redirect_o), 32'(0));
    @(negedge clk);
    rst = 1;
    step("idle");

    // 1: load-use on rs1
    set_ex(1, 1, 4'd3); set_id(1, 4'd3, 4'd7, 0);
    bus.ctrl_i = 8'h38; bus.src1_i = 16'h0011;
    step("t1a"); chk("t1.stall", 32'(obs_stall), 32'(1));
    set_ex(0, 0, 4'd0);
    step("t1b"); chk("t1.free", 32'(obs_stall), 32'(0)); chk("t1.bub", 32'(obs_ivalid), 32'(0));
    idle_in();
    step("t1c"); chk("t1.issue", 32'(obs_ivalid), 32'(1));

    // 2: ALU result feeding BEQZ
    set_ex(0, 1, 4'd2); set_id(1, 4'd2, 4'd0, 0); set_br(1, 0, 2'b01, 16'h0, 16'h0100);
    step("t2a"); chk("t2.stall", 32'(obs_stall), 32'(1)); chk("t2.nored", 32'(obs_redir), 32'(0));
    set_ex(0, 0, 4'd0);
    step("t2b"); chk("t2.redir", 32'(obs_redir), 32'(1)); chk("t2.tgt", 32'(obs_tgt), 32'(16'h0100));

    // 3: load feeding BNEZ, two stall cycles
    set_ex(1, 1, 4'd5); set_id(1, 4'd5, 4'd0, 0); set_br(1, 0, 2'b10, 16'h0, 16'h0200);
    step("t3a"); chk("t3.s1", 32'(obs_stall), 32'(1));
    set_ex(0, 0, 4'd0);
    step("t3b"); chk("t3.s2", 32'(obs_stall), 32'(1));
    bus.rdata1_i = 16'h0007;
    step("t3c"); chk("t3.free", 32'(obs_stall), 32'(0)); chk("t3.redir", 32'(obs_redir), 32'(1));

    // 4: BLTZ sign boundary and JR target
    idle_in(); set_id(1, 4'd1, 4'd0, 0);
    set_br(1, 0, 2'b11, 16'h8000, 16'h0300);
    step("t4a"); chk("t4.neg", 32'(obs_redir), 32'(1));
    bus.rdata1_i = 16'h7FFF;
    step("t4b"); chk("t4.pos", 32'(obs_redir), 32'(0));
    set_br(0, 1, 2'b00, 16'h0040, 16'h0300);
    step("t4c"); chk("t4.jr", 32'(obs_redir), 32'(1)); chk("t4.jrtgt", 32'(obs_tgt), 32'(16'h0040));

    // 5: EX backpressure freezes ID/EX and suppresses redirect
    idle_in(); set_id(1, 4'd1, 4'd2, 1); bus.ctrl_i = 8'h28; bus.src1_i = 16'h1234;
    step("t5l");
    bus.ex_ready_i = 0; bus.src1_i = 16'h5555; set_br(1, 0, 2'b00, 16'h0, 16'h0400);
    for (int i = 0; i < 3; i++) begin
      step("t5h");
      chk("t5.stall", 32'(obs_stall), 32'(1));
      chk("t5.nored", 32'(obs_redir), 32'(0));
      chk("t5.hold", 32'(obs_src1), 32'(16'h1234));
    end
    bus.ex_ready_i = 1;
    step("t5r");

    // 6: reset in the middle of a two-cycle stall
    idle_in(); set_ex(1, 1, 4'd5); set_id(1, 4'd5, 4'd0, 0); set_br(1, 0, 2'b10, 16'h9, 16'h0500);
    step("t6a");
    #2 rst = 0;
    model_reset();
    #1;
    chk("t6.ivalid", 32'(bus.idex_valid_o), 32'(0));
    idle_in();
    @(negedge clk);
    chk("t6.rstall", 32'(bus.stall_o), 32'(0));
    chk("t6.rredir", 32'(bus.redirect_o), 32'(0));
    rst = 1;
    step("t6b"); chk("t6.stall", 32'(obs_stall), 32'(0)); chk("t6.redir", 32'(obs_redir), 32'(0));

    for (int i = 0; i < 500; i++) begin
      rand_in();
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
